// File: rtl/microc_pkg.sv
// microc_pkg
//   Shared constants for the microcontroller control unit: opcode values,
//   opcode class masks, ALU op field position and FSM state encoding.
//   No ports; imported by microc_decode and microc_control.
package microc_pkg;

  // Jump / halt opcodes
  localparam logic [5:0] OPC_J    = 6'b110000;
  localparam logic [5:0] OPC_JZ   = 6'b110001;
  localparam logic [5:0] OPC_JNZ  = 6'b110010;
  localparam logic [5:0] HALT_OPC = 6'b111111;

  // Opcode classes: (opcode & MASK) == MATCH
  localparam logic [5:0] ALU_MASK  = 6'b100000;
  localparam logic [5:0] ALU_MATCH = 6'b000000;
  localparam logic [5:0] LI_MASK   = 6'b110000;
  localparam logic [5:0] LI_MATCH  = 6'b100000;

  // ALU operation field inside the opcode
  localparam int OP_LSB = 2;
  localparam int OP_W   = 3;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  function automatic logic opc_match(input logic [5:0] opc,
                                     input logic [5:0] mask,
                                     input logic [5:0] match);
    return (opc & mask) == match;
  endfunction

endpackage

// File: rtl/microc_decode.sv
// microc_decode
//   Purely combinational instruction decoder. Produces the datapath controls
//   an instruction would drive if it executes this cycle; the caller gates
//   them with its exec condition.
// Ports:
//   i_opcode  [5:0]  opcode at the current PC
//   i_zflag          registered zero flag (result of last ALU instruction)
//   o_s_inc          1 = PC+1, 0 = load jump address
//   o_s_inm          1 = register file writes immediate
//   o_we3            register file write enable
//   o_op      [2:0]  ALU operation
//   o_is_alu         opcode is an ALU instruction (updates zflag)
//   o_is_halt        opcode is HALT
module microc_decode #(
  parameter logic [5:0] HALT_OPC = 6'b111111
) (
  input  logic [5:0] i_opcode,
  input  logic       i_zflag,
  output logic       o_s_inc,
  output logic       o_s_inm,
  output logic       o_we3,
  output logic [2:0] o_op,
  output logic       o_is_alu,
  output logic       o_is_halt
);
  import microc_pkg::*;

  always_comb begin
    o_s_inc   = 1'b1;
    o_s_inm   = 1'b0;
    o_we3     = 1'b0;
    o_op      = 3'b000;
    o_is_alu  = 1'b0;
    o_is_halt = 1'b0;
    // HALT is tested first so a retargeted HALT_OPC overrides the class decode
    if (i_opcode == HALT_OPC) begin
      o_is_halt = 1'b1;
    end else if (opc_match(i_opcode, ALU_MASK, ALU_MATCH)) begin
      o_is_alu = 1'b1;
      o_we3    = 1'b1;
      o_op     = i_opcode[OP_LSB +: OP_W];
    end else if (opc_match(i_opcode, LI_MASK, LI_MATCH)) begin
      o_we3   = 1'b1;
      o_s_inm = 1'b1;
    end else begin
      case (i_opcode)
        OPC_J:   o_s_inc = 1'b0;
        OPC_JZ:  o_s_inc = ~i_zflag;
        OPC_JNZ: o_s_inc = i_zflag;
        default: o_s_inc = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/microc_control.sv
// microc_control
//   Control unit for the microcontroller datapath with run control
//   (start / single-step / halt), a registered zero flag for conditional
//   jumps and a saturating retired-instruction counter. Outputs are
//   combinational so an instruction completes at the same clock edge.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start               begin/resume from IDLE or HALTED
//   i_step_mode           1 = single-step mode
//   i_step                step request, rising edge executes one instruction
//   i_opcode [5:0]        opcode at current PC
//   i_z                   combinational ALU zero
//   o_s_inc, o_s_inm, o_we3, o_op[2:0]   datapath controls
//   o_pc_en               PC load enable
//   o_busy, o_halted      status
//   o_retired [CNT_W-1:0] retired instruction count (saturating)
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | one instruction per cycle
// STEP   | one instruction per rising edge of step
// HALTED | stopped on HALT, PC still points at it
module microc_control #(
  parameter int         CNT_W    = 16,
  parameter logic [5:0] HALT_OPC = 6'b111111
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_step_mode,
  input  logic             i_step,
  input  logic [5:0]       i_opcode,
  input  logic             i_z,
  output logic             o_s_inc,
  output logic             o_s_inm,
  output logic             o_we3,
  output logic [2:0]       o_op,
  output logic             o_pc_en,
  output logic             o_busy,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_retired
);
  import microc_pkg::*;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_zflag;
  logic             r_step_q;
  logic [CNT_W-1:0] r_retired;

  logic             w_dec_s_inc;
  logic             w_dec_s_inm;
  logic             w_dec_we3;
  logic [2:0]       w_dec_op;
  logic             w_is_alu;
  logic             w_is_halt;
  logic             w_step_edge;
  logic             w_exec;
  logic             w_skip;

  microc_decode #(
    .HALT_OPC (HALT_OPC)
  ) u_decode (
    .i_opcode  (i_opcode),
    .i_zflag   (r_zflag),
    .o_s_inc   (w_dec_s_inc),
    .o_s_inm   (w_dec_s_inm),
    .o_we3     (w_dec_we3),
    .o_op      (w_dec_op),
    .o_is_alu  (w_is_alu),
    .o_is_halt (w_is_halt)
  );

  assign w_step_edge = i_step & ~r_step_q;
  assign w_exec      = (r_state == ST_RUN) | ((r_state == ST_STEP) & w_step_edge);
  // Leaving HALTED must step over the HALT still at the PC
  assign w_skip      = (r_state == ST_HALTED) & i_start;

  assign o_pc_en   = (w_exec & ~w_is_halt) | w_skip;
  assign o_we3     = w_exec & w_dec_we3;
  assign o_s_inc   = w_exec ? w_dec_s_inc : 1'b1;
  assign o_s_inm   = w_exec & w_dec_s_inm;
  assign o_op      = w_exec ? w_dec_op : 3'b000;
  assign o_busy    = (r_state == ST_RUN) | (r_state == ST_STEP);
  assign o_halted  = (r_state == ST_HALTED);
  assign o_retired = r_retired;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (i_start) w_state_nxt = i_step_mode ? ST_STEP : ST_RUN;
      end
      ST_RUN: begin
        if (w_is_halt)        w_state_nxt = ST_HALTED;
        else if (i_step_mode) w_state_nxt = ST_STEP;
      end
      ST_STEP: begin
        if (w_step_edge & w_is_halt) w_state_nxt = ST_HALTED;
        else if (!i_step_mode)       w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_zflag   <= 1'b0;
      r_step_q  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_STEP) r_step_q <= i_step;
      if (w_exec & w_is_alu) r_zflag <= i_z;
      if (w_exec && (r_retired != {CNT_W{1'b1}}))
        r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
